// File: rtl/rv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// rv_pipe_pkg
// Shared definitions for the RV32 pipeline: bit positions inside the decoded
// control bundle (used by decoder, forwarding unit, EX and the ID/EX register),
// register-index width, and a small helper for WB write-port hit detection.
// No ports.
// -----------------------------------------------------------------------------
package rv_pipe_pkg;

   // Control bundle bit indices
   localparam int REG_WRITE  = 0;
   localparam int MEM_READ   = 1;
   localparam int MEM_WRITE  = 2;
   localparam int MEM_TO_REG = 3;
   localparam int ALU_SRC    = 4;
   localparam int USES_RS1   = 5;
   localparam int USES_RS2   = 6;
   localparam int BRANCH     = 7;
   localparam int ALU_OP_LSB = 8;
   localparam int ALU_OP_MSB = 11;

   localparam int REG_IDX_W  = 5;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   // True when the WB port is writing a real register that matches idx.
   // x0 is never a hit: it is hard-wired to zero.
   function automatic logic wb_hit(input logic we, input reg_idx_t wb_rd, input reg_idx_t idx);
      return we && (wb_rd != '0) && (wb_rd == idx);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// ID-side handshake and decoded-instruction bundle feeding the ID/EX register.
//   master : decode stage  (drives id_valid + payload, receives id_ready)
//   slave  : ID/EX register (receives id_valid + payload, drives id_ready)
// Signals: id_valid, id_ready, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data,
//          id_rs2_data, id_imm, id_ctrl.
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 12
);
   logic              id_valid;
   logic              id_ready;
   logic [XLEN-1:0]   id_pc;
   logic [4:0]        id_rs1;
   logic [4:0]        id_rs2;
   logic [4:0]        id_rd;
   logic [XLEN-1:0]   id_rs1_data;
   logic [XLEN-1:0]   id_rs2_data;
   logic [XLEN-1:0]   id_imm;
   logic [CTRL_W-1:0] id_ctrl;

   modport master (
      output id_valid, id_pc, id_rs1, id_rs2, id_rd,
             id_rs1_data, id_rs2_data, id_imm, id_ctrl,
      input  id_ready
   );

   modport slave (
      input  id_valid, id_pc, id_rs1, id_rs2, id_rd,
             id_rs1_data, id_rs2_data, id_imm, id_ctrl,
      output id_ready
   );
endinterface

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard term: the instruction in EX is a load whose
// destination is a source the ID instruction actually reads.
// Ports:
//   ex_valid, ex_mem_read, ex_rd     : state of the instruction in EX
//   id_uses_rs1, id_uses_rs2         : ID instruction reads rs1 / rs2
//   id_rs1, id_rs2                   : ID source register indices
//   load_use                         : hazard, ID must wait one cycle
// -----------------------------------------------------------------------------
module load_use_detect (
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       load_use
);
   logic rs1_dep;
   logic rs2_dep;

   assign rs1_dep  = id_uses_rs1 & (id_rs1 == ex_rd);
   assign rs2_dep  = id_uses_rs2 & (id_rs2 == ex_rd);
   // A load to x0 produces nothing to wait for.
   assign load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & (rs1_dep | rs2_dep);
endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage RV32 core, with load-use bubble
// insertion, branch flush, downstream-stall hold, WB refresh of held operands,
// WB bypass on load, and a saturating count of inserted bubbles.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   id (id_ex_stage_if.slave)          : decoded instruction + valid/ready
//   ex_flush                           : taken branch/jump in EX, kill slot
//   ex_stall                           : EX/MEM not advancing, hold slot
//   wb_we, wb_rd, wb_data              : WB register write port
//   ex_valid                           : slot holds a live instruction
//   ex_pc, ex_imm, ex_rs1_data, ex_rs2_data : registered datapath fields
//   ex_rs1, ex_rs2, ex_rd              : registered indices (forwarding unit)
//   ex_ctrl                            : registered control bundle
//   bubble_cnt                         : saturating load-use bubble count
// -----------------------------------------------------------------------------
module id_ex_stage
   import rv_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   id_ex_stage_if.slave      id,
   input  logic              ex_flush,
   input  logic              ex_stall,
   input  logic              wb_we,
   input  logic [4:0]        wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_imm,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic load_use;
   logic bubble;

   load_use_detect u_load_use_detect (
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_ctrl[MEM_READ]),
      .ex_rd       (ex_rd),
      .id_uses_rs1 (id.id_ctrl[USES_RS1]),
      .id_uses_rs2 (id.id_ctrl[USES_RS2]),
      .id_rs1      (id.id_rs1),
      .id_rs2      (id.id_rs2),
      .load_use    (load_use)
   );

   // A flush empties the slot regardless of stall, so ID may always advance then.
   assign id.id_ready = ex_flush | (~ex_stall & ~load_use);

   // Bubble only when nothing higher-priority owns this edge.
   assign bubble = ~ex_flush & ~ex_stall & load_use & id.id_valid;

   // NOTE: registered state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would let later lines see updated state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: datapath fields are reset as well, not just valid/ctrl, so the
         // forwarding unit never sees stale indices after reset.
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_imm      <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_ctrl     <= '0;
      end else if (ex_flush) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
      end else if (ex_stall) begin
         // Held operands would go stale if WB retires their producer meanwhile.
         if (wb_hit(wb_we, wb_rd, ex_rs1)) ex_rs1_data <= wb_data;
         if (wb_hit(wb_we, wb_rd, ex_rs2)) ex_rs2_data <= wb_data;
      end else if (load_use && id.id_valid) begin
         // Zeroed indices keep the forwarding unit from matching on a bubble.
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         ex_rs1   <= '0;
         ex_rs2   <= '0;
         ex_rd    <= '0;
      end else begin
         ex_valid    <= id.id_valid;
         ex_pc       <= id.id_pc;
         ex_imm      <= id.id_imm;
         ex_rs1      <= id.id_rs1;
         ex_rs2      <= id.id_rs2;
         ex_rd       <= id.id_rd;
         ex_ctrl     <= id.id_valid ? id.id_ctrl : '0;
         // The register file is written at the same edge it is read, so the
         // ID read data can be one write behind; take the WB value instead.
         ex_rs1_data <= wb_hit(wb_we, wb_rd, id.id_rs1) ? wb_data : id.id_rs1_data;
         ex_rs2_data <= wb_hit(wb_we, wb_rd, id.id_rs2) ? wb_data : id.id_rs2_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (bubble && !(&bubble_cnt)) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Two instances of id_ex_stage driven by identical inputs: one with the default
// 16-bit bubble counter, one with a 2-bit counter to reach saturation. Directed
// scenarios with literal expectations, then randomized traffic compared every
// cycle against a slot-level model of the register's behaviour.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
   import rv_pipe_pkg::*;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 12;
   localparam logic [CTRL_W-1:0] LW_CTRL  = 12'h03B; // REG_WRITE|MEM_READ|MEM_TO_REG|ALU_SRC|USES_RS1
   localparam logic [CTRL_W-1:0] ADD_CTRL = 12'h061; // REG_WRITE|USES_RS1|USES_RS2

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Stimulus variables
   logic              id_valid;
   logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]        id_rs1, id_rs2, id_rd;
   logic [CTRL_W-1:0] id_ctrl;
   logic              ex_flush, ex_stall, wb_we;
   logic [4:0]        wb_rd;
   logic [XLEN-1:0]   wb_data;

   id_ex_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) ifa ();
   id_ex_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) ifb ();

   assign ifa.id_valid = id_valid;    assign ifb.id_valid = id_valid;
   assign ifa.id_pc = id_pc;          assign ifb.id_pc = id_pc;
   assign ifa.id_rs1 = id_rs1;        assign ifb.id_rs1 = id_rs1;
   assign ifa.id_rs2 = id_rs2;        assign ifb.id_rs2 = id_rs2;
   assign ifa.id_rd = id_rd;          assign ifb.id_rd = id_rd;
   assign ifa.id_rs1_data = id_rs1_data; assign ifb.id_rs1_data = id_rs1_data;
   assign ifa.id_rs2_data = id_rs2_data; assign ifb.id_rs2_data = id_rs2_data;
   assign ifa.id_imm = id_imm;        assign ifb.id_imm = id_imm;
   assign ifa.id_ctrl = id_ctrl;      assign ifb.id_ctrl = id_ctrl;

   // DUT A outputs
   logic              a_valid;
   logic [XLEN-1:0]   a_pc, a_imm, a_d1, a_d2;
   logic [4:0]        a_rs1, a_rs2, a_rd;
   logic [CTRL_W-1:0] a_ctrl;
   logic [15:0]       a_cnt;
   // DUT B outputs
   logic              b_valid;
   logic [XLEN-1:0]   b_pc, b_imm, b_d1, b_d2;
   logic [4:0]        b_rs1, b_rs2, b_rd;
   logic [CTRL_W-1:0] b_ctrl;
   logic [1:0]        b_cnt;

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .id(ifa.slave),
      .ex_flush(ex_flush), .ex_stall(ex_stall),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(a_valid), .ex_pc(a_pc), .ex_imm(a_imm),
      .ex_rs1_data(a_d1), .ex_rs2_data(a_d2),
      .ex_rs1(a_rs1), .ex_rs2(a_rs2), .ex_rd(a_rd),
      .ex_ctrl(a_ctrl), .bubble_cnt(a_cnt)
   );

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .id(ifb.slave),
      .ex_flush(ex_flush), .ex_stall(ex_stall),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(b_valid), .ex_pc(b_pc), .ex_imm(b_imm),
      .ex_rs1_data(b_d1), .ex_rs2_data(b_d2),
      .ex_rs1(b_rs1), .ex_rs2(b_rs2), .ex_rd(b_rd),
      .ex_ctrl(b_ctrl), .bubble_cnt(b_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- Reference model ----------------
   typedef struct {
      bit                v;
      logic [XLEN-1:0]   pc, imm, d1, d2;
      logic [4:0]        rs1, rs2, rd;
      logic [CTRL_W-1:0] ctrl;
   } slot_t;

   slot_t m;
   int    m_cnt;

   function automatic bit model_hazard(input slot_t s);
      bit dep1, dep2;
      dep1 = id_ctrl[USES_RS1] && (id_rs1 == s.rd);
      dep2 = id_ctrl[USES_RS2] && (id_rs2 == s.rd);
      return s.v && s.ctrl[MEM_READ] && (s.rd != 0) && (dep1 || dep2);
   endfunction

   function automatic bit wb_writes(input logic [4:0] r);
      return wb_we && (wb_rd != 0) && (wb_rd == r);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m     = '{default: '0};
         m_cnt = 0;
      end else begin
         slot_t nx;
         nx = m;
         if (ex_flush) begin
            nx.v = 0; nx.ctrl = '0;
         end else if (ex_stall) begin
            if (wb_writes(m.rs1)) nx.d1 = wb_data;
            if (wb_writes(m.rs2)) nx.d2 = wb_data;
         end else if (model_hazard(m) && id_valid) begin
            nx.v = 0; nx.ctrl = '0; nx.rs1 = '0; nx.rs2 = '0; nx.rd = '0;
            m_cnt++;
         end else begin
            nx.v    = id_valid;
            nx.pc   = id_pc;
            nx.imm  = id_imm;
            nx.rs1  = id_rs1;
            nx.rs2  = id_rs2;
            nx.rd   = id_rd;
            nx.ctrl = id_valid ? id_ctrl : '0;
            nx.d1   = wb_writes(id_rs1) ? wb_data : id_rs1_data;
            nx.d2   = wb_writes(id_rs2) ? wb_data : id_rs2_data;
         end
         m = nx;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         logic rdy;
         rdy = ex_flush || (!ex_stall && !model_hazard(m));
         check("a.ready", ifa.id_ready, rdy);
         check("a.valid", a_valid, m.v);
         check("a.ctrl",  a_ctrl, m.ctrl);
         check("a.rs1",   a_rs1, m.rs1);
         check("a.rs2",   a_rs2, m.rs2);
         check("a.rd",    a_rd, m.rd);
         check("a.cnt",   a_cnt, m_cnt);
         if (m.v) begin
            check("a.pc",  a_pc, m.pc);
            check("a.imm", a_imm, m.imm);
            check("a.d1",  a_d1, m.d1);
            check("a.d2",  a_d2, m.d2);
         end
         check("b.ready", ifb.id_ready, rdy);
         check("b.valid", b_valid, m.v);
         check("b.ctrl",  b_ctrl, m.ctrl);
         check("b.cnt",   b_cnt, (m_cnt > 3) ? 3 : m_cnt);
      end
   end

   // ---------------- Stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
      id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_ctrl = '0;
      ex_flush = 0; ex_stall = 0; wb_we = 0; wb_rd = '0; wb_data = '0;
   endtask

   task automatic set_id(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                         input logic [XLEN-1:0] imm, input logic [CTRL_W-1:0] ctrl);
      id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_ctrl = ctrl;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".a_valid"}, a_valid, 0);
      check({tag, ".a_ctrl"},  a_ctrl, 0);
      check({tag, ".a_pc"},    a_pc, 0);
      check({tag, ".a_imm"},   a_imm, 0);
      check({tag, ".a_d1"},    a_d1, 0);
      check({tag, ".a_d2"},    a_d2, 0);
      check({tag, ".a_idx"},   {a_rs1, a_rs2, a_rd}, 0);
      check({tag, ".a_cnt"},   a_cnt, 0);
      check({tag, ".b_valid"}, b_valid, 0);
      check({tag, ".b_ctrl"},  b_ctrl, 0);
      check({tag, ".b_data"},  {b_pc, b_imm, b_d1 ^ b_d2}, 0);
      check({tag, ".b_idx"},   {b_rs1, b_rs2, b_rd}, 0);
      check({tag, ".b_cnt"},   b_cnt, 0);
   endtask

   // ---------------- Test sequence ----------------
   initial begin
      idle();
      rst_n = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1;

      // 1. load-use: lw x5 then add x6,x5,x1
      set_id(32'h100, 5'd2, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h4, LW_CTRL);
      tick();
      set_id(32'h104, 5'd5, 5'd1, 5'd6, 32'h0, 32'h11, 32'h0, ADD_CTRL);
      @(negedge clk);
      check("t1.ready_low", ifa.id_ready, 0);
      check("t1.lw_rd", a_rd, 5);
      tick();
      @(negedge clk);
      check("t1.bub_valid", a_valid, 0);
      check("t1.bub_ctrl", a_ctrl, 0);
      check("t1.bub_cnt", a_cnt, 1);
      check("t1.bub_rd", a_rd, 0);
      tick();
      @(negedge clk);
      check("t1.add_rs1", a_rs1, 5);
      check("t1.add_valid", a_valid, 1);
      check("t1.add_rd", a_rd, 6);

      // 2. load to x0: no hazard
      set_id(32'h108, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, LW_CTRL);
      tick();
      set_id(32'h10C, 5'd0, 5'd1, 5'd7, 32'h0, 32'h0, 32'h0, ADD_CTRL);
      @(negedge clk);
      check("t2.ready", ifa.id_ready, 1);
      tick();
      @(negedge clk);
      check("t2.valid", a_valid, 1);
      check("t2.cnt", a_cnt, 1);

      // 3. stall with WB refresh of held rs2
      set_id(32'h200, 5'd1, 5'd7, 5'd9, 32'h5, 32'h1111, 32'h8, ADD_CTRL);
      tick();
      ex_stall = 1;
      set_id(32'h204, 5'd2, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, ADD_CTRL);
      @(negedge clk); check("t3.ready_c1", ifa.id_ready, 0);
      tick();
      wb_we = 1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
      @(negedge clk); check("t3.ready_c2", ifa.id_ready, 0);
      tick();
      wb_we = 0;
      @(negedge clk); check("t3.ready_c3", ifa.id_ready, 0);
      tick();
      idle();
      @(negedge clk);
      check("t3.rs2_data", a_d2, 32'hDEADBEEF);
      check("t3.rs1_data", a_d1, 32'h5);
      check("t3.rs2", a_rs2, 7);
      check("t3.pc", a_pc, 32'h200);
      check("t3.rd", a_rd, 9);

      // 4. flush beats stall and load-use
      set_id(32'h300, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, LW_CTRL);
      tick();
      set_id(32'h304, 5'd5, 5'd1, 5'd6, 32'h0, 32'h0, 32'h0, ADD_CTRL);
      ex_flush = 1; ex_stall = 1;
      @(negedge clk);
      check("t4.ready", ifa.id_ready, 1);
      tick();
      idle();
      @(negedge clk);
      check("t4.valid", a_valid, 0);
      check("t4.ctrl", a_ctrl, 0);
      check("t4.cnt", a_cnt, 1);

      // 5. WB bypass on load
      set_id(32'h400, 5'd3, 5'd4, 5'd10, 32'h10, 32'h20, 32'h0, ADD_CTRL);
      wb_we = 1; wb_rd = 5'd3; wb_data = 32'h99;
      tick();
      idle();
      @(negedge clk);
      check("t5.rs1_data", a_d1, 32'h99);
      check("t5.rs2_data", a_d2, 32'h20);

      // 6. five more bubbles: 16-bit counter reaches 6, 2-bit saturates at 3
      for (int i = 0; i < 5; i++) begin
         set_id(32'h500, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, LW_CTRL);
         tick();
         set_id(32'h504, 5'd1, 5'd5, 5'd6, 32'h0, 32'h0, 32'h0, ADD_CTRL);
         tick();
      end
      @(negedge clk);
      check("t6.cnt_a", a_cnt, 6);
      check("t6.cnt_b", b_cnt, 3);
      // reset pulse in the middle of a stall
      set_id(32'h600, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h4, LW_CTRL);
      tick();
      ex_stall = 1;
      tick();
      #2 rst_n = 0;
      #1 check_all_zero("t6.rst");
      #2 rst_n = 1;
      tick();
      ex_stall = 0;
      id_valid = 0;
      @(negedge clk);
      check("t6.post_valid", a_valid, 0);

      // Randomized traffic, checked by the every-cycle compare process
      for (int c = 0; c < 3000; c++) begin
         tick();
         id_valid    = ($urandom_range(0, 9) < 8);
         id_pc       = $urandom;
         id_imm      = $urandom;
         id_rs1      = 5'($urandom_range(0, 7));
         id_rs2      = 5'($urandom_range(0, 7));
         id_rd       = 5'($urandom_range(0, 7));
         id_rs1_data = $urandom;
         id_rs2_data = $urandom;
         id_ctrl     = CTRL_W'($urandom);
         ex_stall    = ($urandom_range(0, 9) < 2);
         ex_flush    = ($urandom_range(0, 9) < 1);
         wb_we       = $urandom_range(0, 1);
         wb_rd       = 5'($urandom_range(0, 7));
         wb_data     = $urandom;
      end
      tick();
      idle();
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
